// File: rtl/counter_checker_pkg.sv
// ============================================================================
//  Module      : counter_checker_pkg
//  Description : Shared constants for the GPIF counter receive checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_checker_pkg;

    // Default widths of the DQ word and the saturating error counter
    localparam int c_data_w = 32;
    localparam int c_err_w  = 6;

    // FSM state encodings
    localparam logic [0:0] c_st_seek  = 1'b0;
    localparam logic [0:0] c_st_track = 1'b1;

    // LED bit positions and the width of the LED error-count field
    localparam int c_led_sync  = 7;
    localparam int c_led_err   = 6;
    localparam int c_led_cnt_w = 6;

    // Largest error count that the LED field can show
    localparam logic [c_led_cnt_w-1:0] c_led_cnt_max = '1;

endpackage : counter_checker_pkg

`default_nettype wire

// File: rtl/dq_capture.sv
// ============================================================================
//  Module      : dq_capture
//  Description : Registers the GPIF write strobe and DQ word; emits valid/data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dq_capture #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_n,
    input  logic [DATA_W-1:0] i_dq,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_wr_n;
    logic [DATA_W-1:0] r_dq;

    // The strobe resets inactive so nothing sampled during reset is seen later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_n <= 1'b1;
            r_dq   <= '0;
        end else begin
            r_wr_n <= i_wr_n;
            r_dq   <= i_dq;
        end
    end

    assign o_valid = ~r_wr_n;
    assign o_data  = r_dq;

endmodule : dq_capture

`default_nettype wire

// File: rtl/counter_checker.sv
// ============================================================================
//  Module      : counter_checker
//  Description : Verifies GPIF DQ words as an incrementing sequence; drives
//                sync/error status, saturating error and wrapping word counts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ERR_W  = c_err_w     // must be at least 6 to fill the LED field
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              WR_n,
    input  logic [DATA_W-1:0] DQ,
    output logic [7:0]        LED,
    output logic              SYNC,
    output logic              ERR_STICKY,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [31:0]       WORD_CNT
);

    localparam logic [ERR_W-1:0] c_err_max = '1;

    logic                   w_valid;
    logic [DATA_W-1:0]      w_data;
    logic                   w_mismatch;
    logic [c_led_cnt_w-1:0] w_led_cnt;

    logic [0:0]             r_state;
    logic [DATA_W-1:0]      r_expected;
    logic [ERR_W-1:0]       r_err_cnt;
    logic                   r_err_sticky;
    logic [31:0]            r_word_cnt;

    dq_capture #(
        .DATA_W (DATA_W)
    ) u_dq_capture (
        .clk     (PCLK),
        .rst     (RESET),
        .i_wr_n  (WR_n),
        .i_dq    (DQ),
        .o_valid (w_valid),
        .o_data  (w_data)
    );

    // The seed word in SEEK is never checked
    assign w_mismatch = (r_state == c_st_track) && (w_data != r_expected);

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            r_state      <= c_st_seek;
            r_expected   <= '0;
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
            r_word_cnt   <= '0;
        end else if (w_valid) begin
            // Always resync to the received word: one dropped word costs one error
            r_expected <= w_data + DATA_W'(1);
            r_state    <= c_st_track;
            if (r_state == c_st_seek) begin
                r_word_cnt <= 32'd1;
            end else begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
            if (w_mismatch) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != c_err_max) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
            end
        end
    end

    generate
        if (ERR_W > c_led_cnt_w) begin : g_led_sat
            assign w_led_cnt = (r_err_cnt > ERR_W'(c_led_cnt_max))
                             ? c_led_cnt_max
                             : r_err_cnt[c_led_cnt_w-1:0];
        end else begin : g_led_direct
            assign w_led_cnt = r_err_cnt[c_led_cnt_w-1:0];
        end
    endgenerate

    assign SYNC       = (r_state == c_st_track);
    assign ERR_STICKY = r_err_sticky;
    assign ERR_CNT    = r_err_cnt;
    assign WORD_CNT   = r_word_cnt;

    always_comb begin
        LED             = '0;
        LED[c_led_sync] = SYNC;
        LED[c_led_err]  = r_err_sticky;
        LED[c_led_cnt_w-1:0] = w_led_cnt;
    end

endmodule : counter_checker

`default_nettype wire
